// File: rtl/cpu_sequencer_if.sv
// Control and memory-handshake bundle between cpu_sequencer (master) and the datapath/memory (slave).
interface cpu_sequencer_if;
  logic [31:0] mdr_q;
  logic        mem_ready, mem_read, mem_write, mdr_read;
  logic [15:0] r_select;
  logic        PC_select, MDR_select, InPort_select, HI_select, LO_select, ZHI_select, ZLO_select;
  logic        PC_select_write, MDR_select_write, MAR_select_write, OutPort_select_write;
  logic        HI_select_write, LO_select_write, ZHI_select_write, ZLO_select_write;
  logic        RY_select_write, InPort_select_write;
  logic        RF_enable;
  logic [3:0]  RF_write;
  logic        pc_inc;
  logic [12:0] alu_op;

  modport master (
    input  mdr_q, mem_ready,
    output mem_read, mem_write, mdr_read, r_select,
           PC_select, MDR_select, InPort_select, HI_select, LO_select, ZHI_select, ZLO_select,
           PC_select_write, MDR_select_write, MAR_select_write, OutPort_select_write,
           HI_select_write, LO_select_write, ZHI_select_write, ZLO_select_write,
           RY_select_write, InPort_select_write, RF_enable, RF_write, pc_inc, alu_op
  );

  modport slave (
    output mdr_q, mem_ready,
    input  mem_read, mem_write, mdr_read, r_select,
           PC_select, MDR_select, InPort_select, HI_select, LO_select, ZHI_select, ZLO_select,
           PC_select_write, MDR_select_write, MAR_select_write, OutPort_select_write,
           HI_select_write, LO_select_write, ZHI_select_write, ZLO_select_write,
           RY_select_write, InPort_select_write, RF_enable, RF_write, pc_inc, alu_op
  );
endinterface

// File: rtl/cpu_sequencer.sv
// Hardwired fetch/execute sequencer for the single-bus CPU; outputs decode registered state/IR (+mem_ready).
// Optional memory-wait watchdog enabled by `define CPU_SEQ_MEM_TIMEOUT_EN (TIMEOUT_CYCLES).
module cpu_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             run,
  cpu_sequencer_if.master  bus,
  output logic             busy,
  output logic             halted,
  output logic             fault
);
  localparam logic [3:0] S_IDLE = 4'd0, S_F0 = 4'd1, S_F1 = 4'd2, S_F2 = 4'd3, S_E3 = 4'd4,
                         S_E4 = 4'd5, S_E5 = 4'd6, S_E6 = 4'd7, S_HALT = 4'd8;

  logic [3:0]  state, state_nxt;
  logic [31:0] ir;
  logic [4:0]  op, fetch_op;
  logic [3:0]  ra, rb, rc;
  logic        is_alu, is_muldiv, is_ld, is_st, is_mfhi, is_mflo, is_in, is_out;
  logic        fetch_halt, fetch_illegal, mem_wait, wd_expire, rf_en;
  logic        unused_ir_bits;

  assign op       = ir[31:27];
  assign ra       = ir[26:23];
  assign rb       = ir[22:19];
  assign rc       = ir[18:15];
  assign unused_ir_bits = ^ir[14:0];

  assign is_alu    = (op <= 5'd12);
  assign is_muldiv = (op == 5'd9) || (op == 5'd10);
  assign is_ld     = (op == 5'd13);
  assign is_st     = (op == 5'd14);
  assign is_mfhi   = (op == 5'd15);
  assign is_mflo   = (op == 5'd16);
  assign is_in     = (op == 5'd17);
  assign is_out    = (op == 5'd18);

  // HALT and illegal opcodes are caught while the word is still on mdr_q, before any execute step.
  assign fetch_op      = bus.mdr_q[31:27];
  assign fetch_halt    = (fetch_op == 5'd31);
  assign fetch_illegal = (fetch_op > 5'd18) && !fetch_halt;

  assign mem_wait = (state == S_F1) || (state == S_E4 && is_ld) || (state == S_E5 && is_st);

`ifdef CPU_SEQ_MEM_TIMEOUT_EN
  localparam int unsigned WD_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [WD_W-1:0] wd;

  assign wd_expire = mem_wait && !bus.mem_ready && (wd == WD_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!clr)                                           wd <= '0;
    else if (mem_wait && !bus.mem_ready && !wd_expire) wd <= wd + 1'b1;
    else                                                wd <= '0;
  end
`else
  assign wd_expire = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (run) state_nxt = S_F0;
      S_F0:   state_nxt = S_F1;
      S_F1:   if (bus.mem_ready) state_nxt = S_F2; else if (wd_expire) state_nxt = S_HALT;
      S_F2:   state_nxt = (fetch_halt || fetch_illegal) ? S_HALT : S_E3;
      S_E3:   state_nxt = (is_alu || is_ld || is_st) ? S_E4 : S_F0;
      S_E4: begin
        if (!is_ld || bus.mem_ready) state_nxt = S_E5;
        else if (wd_expire)          state_nxt = S_HALT;
      end
      S_E5: begin
        if (is_muldiv)                      state_nxt = S_E6;
        else if (!is_st || bus.mem_ready)   state_nxt = S_F0;
        else if (wd_expire)                 state_nxt = S_HALT;
      end
      S_E6:   state_nxt = S_F0;
      S_HALT: if (run) state_nxt = S_F0;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      state <= S_IDLE;
      ir    <= '0;
      fault <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == S_F2) ir <= bus.mdr_q;
      if ((state == S_F2 && fetch_illegal) || wd_expire) fault <= 1'b1;
      else if (state == S_HALT && run)                   fault <= 1'b0;
    end
  end

  assign busy   = (state >= S_F0) && (state <= S_E6);
  assign halted = (state == S_HALT);

  always_comb begin
    bus.mem_read = 1'b0;  bus.mem_write = 1'b0;  bus.mdr_read = 1'b0;
    bus.r_select = '0;
    bus.PC_select = 1'b0;  bus.MDR_select = 1'b0;  bus.InPort_select = 1'b0;
    bus.HI_select = 1'b0;  bus.LO_select = 1'b0;  bus.ZHI_select = 1'b0;  bus.ZLO_select = 1'b0;
    bus.PC_select_write = 1'b0;  bus.MDR_select_write = 1'b0;  bus.MAR_select_write = 1'b0;
    bus.OutPort_select_write = 1'b0;  bus.HI_select_write = 1'b0;  bus.LO_select_write = 1'b0;
    bus.ZHI_select_write = 1'b0;  bus.ZLO_select_write = 1'b0;  bus.RY_select_write = 1'b0;
    bus.InPort_select_write = 1'b0;
    bus.pc_inc = 1'b0;
    bus.alu_op = '0;
    rf_en = 1'b0;
    case (state)
      S_F0: begin
        bus.PC_select = 1'b1;  bus.MAR_select_write = 1'b1;  bus.pc_inc = 1'b1;
      end
      S_F1: begin
        bus.mem_read = 1'b1;  bus.mdr_read = 1'b1;  bus.MDR_select_write = bus.mem_ready;
      end
      S_E3: begin
        if (is_alu || is_ld || is_st) begin
          bus.r_select = 16'd1 << rb;
          if (is_alu) bus.RY_select_write  = 1'b1;
          else        bus.MAR_select_write = 1'b1;
        end else if (is_mfhi) begin
          bus.HI_select = 1'b1;  rf_en = 1'b1;
        end else if (is_mflo) begin
          bus.LO_select = 1'b1;  rf_en = 1'b1;
        end else if (is_in) begin
          bus.InPort_select = 1'b1;  rf_en = 1'b1;
        end else if (is_out) begin
          bus.r_select = 16'd1 << ra;  bus.OutPort_select_write = 1'b1;
        end
      end
      S_E4: begin
        if (is_alu) begin
          // NEG/NOT are unary: the operand comes from Rb, not Rc.
          bus.r_select = 16'd1 << ((op == 5'd11 || op == 5'd12) ? rb : rc);
          bus.ZLO_select_write = 1'b1;  bus.ZHI_select_write = 1'b1;
          case (op)
            5'd0:  bus.alu_op = 13'd1 << 2;
            5'd1:  bus.alu_op = 13'd1 << 3;
            5'd2:  bus.alu_op = 13'd1 << 0;
            5'd3:  bus.alu_op = 13'd1 << 1;
            5'd4:  bus.alu_op = 13'd1 << 6;
            5'd5:  bus.alu_op = 13'd1 << 7;
            5'd6:  bus.alu_op = 13'd1 << 8;
            5'd7:  bus.alu_op = 13'd1 << 9;
            5'd8:  bus.alu_op = 13'd1 << 10;
            5'd9:  bus.alu_op = 13'd1 << 4;
            5'd10: bus.alu_op = 13'd1 << 5;
            5'd11: bus.alu_op = 13'd1 << 11;
            default: bus.alu_op = 13'd1 << 12;
          endcase
        end else if (is_ld) begin
          bus.mem_read = 1'b1;  bus.mdr_read = 1'b1;  bus.MDR_select_write = bus.mem_ready;
        end else if (is_st) begin
          bus.r_select = 16'd1 << ra;  bus.MDR_select_write = 1'b1;
        end
      end
      S_E5: begin
        if (is_alu) begin
          bus.ZLO_select = 1'b1;
          if (is_muldiv) bus.LO_select_write = 1'b1;
          else           rf_en = 1'b1;
        end else if (is_ld) begin
          bus.MDR_select = 1'b1;  rf_en = 1'b1;
        end else if (is_st) begin
          bus.mem_write = 1'b1;
        end
      end
      S_E6: begin
        bus.ZHI_select = 1'b1;  bus.HI_select_write = 1'b1;
      end
      default: ;
    endcase
    bus.RF_enable = rf_en;
    bus.RF_write  = rf_en ? ra : 4'd0;
  end
endmodule

// File: tb/tb_cpu_sequencer.sv
// Bench for cpu_sequencer: per-cycle expected control words built from instruction-level step lists.
`timescale 1ns/1ps
module tb_cpu_sequencer;
  logic clk = 1'b0;
  logic clr, run, busy, halted, fault;
  cpu_sequencer_if bus();

  cpu_sequencer #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .clr(clr), .run(run), .bus(bus), .busy(busy), .halted(halted), .fault(fault)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] rsel;
    logic [6:0]  src;
    logic [9:0]  wr;
    logic        rfe;
    logic [3:0]  rfw;
    logic        pcinc, mrd, mwr, mdrrd;
    logic [12:0] alu;
    logic        busy, halted, fault;
  } ctl_t;

  typedef struct {
    logic  rdy, run, clr;
    ctl_t  exp;
    string tag;
  } step_t;

  localparam int BS_PC = 6, BS_MDR = 5, BS_IN = 4, BS_HI = 3, BS_LO = 2, BS_ZHI = 1, BS_ZLO = 0;
  localparam int BW_PC = 9, BW_MDR = 8, BW_MAR = 7, BW_OUT = 6, BW_HI = 5, BW_LO = 4,
                 BW_ZHI = 3, BW_ZLO = 2, BW_RY = 1, BW_IN = 0;
  // alu_op bit for opcodes 0..12, from {NOT,NEG,ROL,ROR,SHL,SHRA,SHR,DIV,MUL,SUB,ADD,OR,AND}
  localparam int ALU_BIT [13] = '{2, 3, 0, 1, 6, 7, 8, 9, 10, 4, 5, 11, 12};
`ifdef CPU_SEQ_MEM_TIMEOUT_EN
  localparam int MAXW = 3;
`else
  localparam int MAXW = 5;
`endif

  step_t q[$];
  int n_checks = 0;
  int n_pass   = 0;

  function automatic logic rnd();
    return logic'($urandom_range(0, 1));
  endfunction

  function automatic ctl_t bc();
    ctl_t c = '0;
    c.busy = 1'b1;
    return c;
  endfunction

  function automatic logic [31:0] enc(int op, int ra, int rb, int rc);
    logic [31:0] w;
    w = '0;
    w[31:27] = 5'(op);  w[26:23] = 4'(ra);  w[22:19] = 4'(rb);  w[18:15] = 4'(rc);
    return w;
  endfunction

  function automatic ctl_t observe();
    ctl_t o;
    o.rsel  = bus.r_select;
    o.src   = {bus.PC_select, bus.MDR_select, bus.InPort_select, bus.HI_select,
               bus.LO_select, bus.ZHI_select, bus.ZLO_select};
    o.wr    = {bus.PC_select_write, bus.MDR_select_write, bus.MAR_select_write,
               bus.OutPort_select_write, bus.HI_select_write, bus.LO_select_write,
               bus.ZHI_select_write, bus.ZLO_select_write, bus.RY_select_write,
               bus.InPort_select_write};
    o.rfe   = bus.RF_enable;  o.rfw = bus.RF_write;
    o.pcinc = bus.pc_inc;     o.mrd = bus.mem_read;  o.mwr = bus.mem_write;
    o.mdrrd = bus.mdr_read;   o.alu = bus.alu_op;
    o.busy  = busy;  o.halted = halted;  o.fault = fault;
    return o;
  endfunction

  task automatic push(string tag, logic rdy, logic r, logic c_n, ctl_t c);
    step_t s;
    s.tag = tag;  s.rdy = rdy;  s.run = r;  s.clr = c_n;  s.exp = c;
    q.push_back(s);
  endtask

  // run and mem_ready are randomised wherever the sequencer must ignore them
  task automatic pushr(string tag, ctl_t c);
    push(tag, rnd(), rnd(), 1'b1, c);
  endtask

  task automatic check(string tag, ctl_t o, ctl_t e);
    n_checks++;
    assert (o === e) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, o, e);
  endtask

  task automatic drain();
    step_t s;
    while (q.size() > 0) begin
      s = q.pop_front();
      @(negedge clk);
      bus.mem_ready = s.rdy;  run = s.run;  clr = s.clr;
      #1;
      check(s.tag, observe(), s.exp);
    end
  endtask

  task automatic mem_rd(string tag, int nwait);
    ctl_t c = bc();
    c.mrd = 1'b1;  c.mdrrd = 1'b1;
    for (int i = 0; i < nwait; i++) push({tag, "_wait"}, 1'b0, rnd(), 1'b1, c);
    c.wr[BW_MDR] = 1'b1;
    push(tag, 1'b1, rnd(), 1'b1, c);
  endtask

  task automatic fetch(int nwait);
    ctl_t c = bc();
    c.src[BS_PC] = 1'b1;  c.wr[BW_MAR] = 1'b1;  c.pcinc = 1'b1;
    pushr("f0", c);
    mem_rd("f1", nwait);
    pushr("f2", bc());
  endtask

  task automatic instr(logic [31:0] w, int nf, int ne, bit abort_st);
    logic [4:0] op;
    logic [3:0] ra, rb, rc;
    ctl_t c;
    op = w[31:27];  ra = w[26:23];  rb = w[22:19];  rc = w[18:15];
    bus.mdr_q = w;
    fetch(nf);
    if (op == 5'd31 || op > 5'd18) begin
      c = '0;  c.halted = 1'b1;  c.fault = (op != 5'd31);
      push("halt_hold", rnd(), 1'b0, 1'b1, c);
      push("halt_run",  rnd(), 1'b1, 1'b1, c);
    end else if (op <= 5'd12) begin
      c = bc();  c.rsel = 16'd1 << rb;  c.wr[BW_RY] = 1'b1;  pushr("alu_e3", c);
      c = bc();  c.rsel = 16'd1 << ((op == 5'd11 || op == 5'd12) ? rb : rc);
      c.alu = 13'd1 << ALU_BIT[op];  c.wr[BW_ZHI] = 1'b1;  c.wr[BW_ZLO] = 1'b1;
      pushr("alu_e4", c);
      c = bc();  c.src[BS_ZLO] = 1'b1;
      if (op == 5'd9 || op == 5'd10) c.wr[BW_LO] = 1'b1;
      else begin c.rfe = 1'b1;  c.rfw = ra; end
      pushr("alu_e5", c);
      if (op == 5'd9 || op == 5'd10) begin
        c = bc();  c.src[BS_ZHI] = 1'b1;  c.wr[BW_HI] = 1'b1;  pushr("alu_e6", c);
      end
    end else begin
      case (op)
        5'd13: begin
          c = bc();  c.rsel = 16'd1 << rb;  c.wr[BW_MAR] = 1'b1;  pushr("ld_e3", c);
          mem_rd("ld_e4", ne);
          c = bc();  c.src[BS_MDR] = 1'b1;  c.rfe = 1'b1;  c.rfw = ra;  pushr("ld_e5", c);
        end
        5'd14: begin
          c = bc();  c.rsel = 16'd1 << rb;  c.wr[BW_MAR] = 1'b1;  pushr("st_e3", c);
          c = bc();  c.rsel = 16'd1 << ra;  c.wr[BW_MDR] = 1'b1;  pushr("st_e4", c);
          c = bc();  c.mwr = 1'b1;
          if (abort_st) begin
            push("st_e5_clr", 1'b0, rnd(), 1'b0, c);
            push("after_clr", rnd(), 1'b0, 1'b1, '0);
            push("restart",   rnd(), 1'b1, 1'b1, '0);
          end else begin
            for (int i = 0; i < ne; i++) push("st_e5_wait", 1'b0, rnd(), 1'b1, c);
            push("st_e5", 1'b1, rnd(), 1'b1, c);
          end
        end
        5'd15: begin c = bc(); c.src[BS_HI] = 1'b1; c.rfe = 1'b1; c.rfw = ra; pushr("mfhi", c); end
        5'd16: begin c = bc(); c.src[BS_LO] = 1'b1; c.rfe = 1'b1; c.rfw = ra; pushr("mflo", c); end
        5'd17: begin c = bc(); c.src[BS_IN] = 1'b1; c.rfe = 1'b1; c.rfw = ra; pushr("in", c); end
        default: begin c = bc(); c.rsel = 16'd1 << ra; c.wr[BW_OUT] = 1'b1; pushr("out", c); end
      endcase
    end
    drain();
  endtask

  initial begin
    clr = 1'b0;  run = 1'b0;  bus.mem_ready = 1'b0;  bus.mdr_q = '0;
    repeat (2) @(posedge clk);
    push("reset",      1'b1, 1'b1, 1'b0, '0);
    push("idle",       1'b1, 1'b0, 1'b1, '0);
    push("idle_run",   1'b0, 1'b1, 1'b1, '0);
    drain();

    instr(32'h0091_8000, 0, 0, 1'b0);       // ADD R1,R2,R3
    instr(enc(9, 4, 5, 6), 0, 0, 1'b0);     // MUL R4,R5,R6
    instr(enc(13, 7, 2, 0), 3, 3, 1'b0);    // LD R7,(R2), three wait cycles each access
    instr(enc(11, 8, 9, 10), 1, 0, 1'b0);   // NEG uses Rb
    instr(enc(10, 3, 1, 2), 0, 0, 1'b0);    // DIV
    instr(enc(14, 5, 6, 0), 0, 2, 1'b0);    // ST with E5 wait
    instr(enc(20, 1, 1, 1), 0, 0, 1'b0);    // illegal opcode -> fault, then run clears it
    instr(enc(15, 2, 0, 0), 0, 0, 1'b0);
    instr(enc(16, 3, 0, 0), 0, 0, 1'b0);
    instr(enc(17, 4, 0, 0), 0, 0, 1'b0);
    instr(enc(18, 6, 0, 0), 0, 0, 1'b0);
    instr(enc(31, 0, 0, 0), 2, 0, 1'b0);    // HALT
    instr(enc(14, 9, 4, 0), 0, 3, 1'b1);    // ST aborted by clr in E5 wait

`ifdef CPU_SEQ_MEM_TIMEOUT_EN
    begin
      ctl_t c;
      bus.mdr_q = enc(0, 1, 2, 3);
      c = bc();  c.src[BS_PC] = 1'b1;  c.wr[BW_MAR] = 1'b1;  c.pcinc = 1'b1;
      pushr("tmo_f0", c);
      c = bc();  c.mrd = 1'b1;  c.mdrrd = 1'b1;
      for (int i = 0; i < 4; i++) push("tmo_f1_wait", 1'b0, 1'b0, 1'b1, c);
      c = '0;  c.halted = 1'b1;  c.fault = 1'b1;
      push("tmo_halt",     1'b0, 1'b0, 1'b1, c);
      push("tmo_halt_run", 1'b0, 1'b1, 1'b1, c);
      drain();
    end
    instr(enc(13, 2, 3, 0), 3, 3, 1'b0);    // ready on the last allowed wait cycle wins
`else
    instr(enc(2, 1, 2, 3), 12, 0, 1'b0);    // long waits are unbounded
`endif

    for (int n = 0; n < 40; n++) begin
      int op;
      op = (n % 13 == 12) ? ((n % 2 == 0) ? 31 : int'($urandom_range(19, 30)))
                          : int'($urandom_range(0, 18));
      instr(enc(op, $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15)),
            $urandom_range(0, MAXW), $urandom_range(0, MAXW), 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
